// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: sequencer for the single off-chip bus.
// Arbitrates fetch vs load/store, steers lanes, times out.
module ext_bus_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int TO_CYC = 255
) (
  input  logic              clk,
  input  logic              a_reset_l,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic              ls_err,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              bus_en,
  output logic              bus_wen,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] load_data,
  input  logic              bus_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERRESP,
    TURN
  } state_t;

  // Last ACCESS cycle index; ready in this cycle still wins.
  localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

  state_t state_q;
  state_t state_d;

  logic              last_ls, last_ls_d;
  logic              own_ls, own_ls_d;
  logic [7:0]        cnt, cnt_d;

  logic              pick_ls;
  logic              pick_any;
  logic              legal;
  logic              w_we;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_lanes;
  logic [DATA_W-1:0] rd_lane;
  logic              tmo;

  logic              bus_en_d, bus_wen_d;
  logic [1:0]        bus_size_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] store_data_d;
  logic              if_gnt_d, if_done_d, if_err_d;
  logic              ls_gnt_d, ls_done_d, ls_err_d;
  logic [DATA_W-1:0] if_rdata_d, ls_rdata_d;

  // Pick a winner (alternate on contention) and vet its alignment
  always_comb begin
    pick_ls  = ls_req && !(if_req && last_ls);
    pick_any = ls_req || if_req;
    w_we     = pick_ls ? ls_we : 1'b0;
    w_size   = pick_ls ? ls_size : 2'b10;
    w_addr   = pick_ls ? ls_addr : if_addr;
    unique case (w_size)
      2'b00: begin
        legal   = 1'b1;
        w_lanes = {4{ls_wdata[7:0]}};
      end
      2'b01: begin
        legal   = !w_addr[0];
        w_lanes = {2{ls_wdata[15:0]}};
      end
      2'b10: begin
        legal   = (w_addr[1:0] == 2'b00);
        w_lanes = ls_wdata;
      end
      default: begin
        legal   = 1'b0;
        w_lanes = ls_wdata;
      end
    endcase
  end

  // Pull the addressed lane out of the read word, zero-extended
  always_comb begin
    unique case (bus_size)
      2'b00:
        rd_lane = {24'b0, load_data[{bus_addr[1:0], 3'b000} +: 8]};
      2'b01:
        rd_lane = bus_addr[1] ? {16'b0, load_data[31:16]}
                              : {16'b0, load_data[15:0]};
      default:
        rd_lane = load_data;
    endcase
    tmo = (state_q == ACCESS) && !bus_ready && (cnt == TO_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) state_d = legal ? ACCESS : ERRESP;
      end
      ACCESS: begin
        if (bus_ready) state_d = bus_wen ? TURN : IDLE;
        else if (tmo)  state_d = TURN;
      end
      ERRESP: state_d = IDLE;
      TURN:   state_d = IDLE;
    endcase
  end

  // Next values for all registered outputs and datapath state
  always_comb begin
    bus_en_d     = bus_en;
    bus_wen_d    = bus_wen;
    bus_size_d   = bus_size;
    bus_addr_d   = bus_addr;
    store_data_d = store_data;
    if_rdata_d   = if_rdata;
    ls_rdata_d   = ls_rdata;
    last_ls_d    = last_ls;
    own_ls_d     = own_ls;
    cnt_d        = cnt;
    if_gnt_d     = 1'b0;
    if_done_d    = 1'b0;
    if_err_d     = 1'b0;
    ls_gnt_d     = 1'b0;
    ls_done_d    = 1'b0;
    ls_err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          last_ls_d = pick_ls;
          own_ls_d  = pick_ls;
          if_gnt_d  = !pick_ls;
          ls_gnt_d  = pick_ls;
          if (legal) begin
            bus_en_d     = 1'b1;
            bus_wen_d    = w_we;
            bus_size_d   = w_size;
            bus_addr_d   = w_addr;
            store_data_d = w_lanes;
            cnt_d        = 8'd0;
          end else begin
            if_done_d = !pick_ls;
            if_err_d  = !pick_ls;
            ls_done_d = pick_ls;
            ls_err_d  = pick_ls;
          end
        end
      end
      ACCESS: begin
        if (bus_ready || tmo) begin
          bus_en_d  = 1'b0;
          bus_wen_d = 1'b0;
          if_done_d = !own_ls;
          ls_done_d = own_ls;
          if_err_d  = !own_ls && !bus_ready;
          ls_err_d  = own_ls && !bus_ready;
          if (!bus_ready) begin
            if (own_ls) ls_rdata_d = '0;
            else        if_rdata_d = '0;
          end else if (!bus_wen) begin
            if (own_ls) ls_rdata_d = rd_lane;
            else        if_rdata_d = rd_lane;
          end
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // Output and datapath registers; reset kills any bus cycle at once
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      bus_en     <= 1'b0;
      bus_wen    <= 1'b0;
      bus_size   <= 2'b00;
      bus_addr   <= '0;
      store_data <= '0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      last_ls    <= 1'b0;
      own_ls     <= 1'b0;
      cnt        <= 8'd0;
      if_gnt     <= 1'b0;
      if_done    <= 1'b0;
      if_err     <= 1'b0;
      ls_gnt     <= 1'b0;
      ls_done    <= 1'b0;
      ls_err     <= 1'b0;
    end else begin
      bus_en     <= bus_en_d;
      bus_wen    <= bus_wen_d;
      bus_size   <= bus_size_d;
      bus_addr   <= bus_addr_d;
      store_data <= store_data_d;
      if_rdata   <= if_rdata_d;
      ls_rdata   <= ls_rdata_d;
      last_ls    <= last_ls_d;
      own_ls     <= own_ls_d;
      cnt        <= cnt_d;
      if_gnt     <= if_gnt_d;
      if_done    <= if_done_d;
      if_err     <= if_err_d;
      ls_gnt     <= ls_gnt_d;
      ls_done    <= ls_done_d;
      ls_err     <= ls_err_d;
    end
  end

endmodule
